// File: rtl/card_deal_generator.sv
// Builds a fresh pair deck each game, Fisher-Yates shuffles it with a free-running
// Galois LFSR, then streams colour/state for every card slot into card memory.
module card_deal_generator #(
    parameter int          ADDR_W    = 5,
    parameter int          NUM_W     = 6,
    parameter int          COLOR_W   = 12,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_game_en,
    input  logic [NUM_W-1:0]   num_of_cards,
    output logic               compute_done,
    output logic               card_wr_en,
    output logic [ADDR_W-1:0]  card_wr_address,
    output logic [COLOR_W-1:0] card_wr_color,
    output logic [1:0]         card_wr_state
);
    localparam int                SLOTS = 1 << ADDR_W;
    localparam logic [NUM_W-1:0]  MAX_N = NUM_W'(SLOTS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(SLOTS - 1);
    localparam logic [11:0] PALETTE [16] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80, 12'h8F0,
        12'h08F, 12'hF08, 12'h80F, 12'h0F8, 12'hFFF, 12'h888, 12'h840, 12'h48C
    };

    typedef enum logic [2:0] {
        IDLE, FILL, SHUFFLE, SWAP, EMIT, DONE
    } state_t;

    state_t              r_state;
    logic [15:0]         r_lfsr;
    logic [ADDR_W-2:0]   r_deck [SLOTS];
    logic [NUM_W-1:0]    r_n;
    logic [ADDR_W-1:0]   r_i;
    logic [ADDR_W-1:0]   r_j;
    logic [ADDR_W-1:0]   r_a;
    logic [NUM_W-1:0]    w_clamp;
    logic [NUM_W-1:0]    w_n_req;
    logic [ADDR_W-1:0]   w_cand;
    logic                w_busy;

    assign w_clamp = (num_of_cards > MAX_N) ? MAX_N : num_of_cards;
    assign w_n_req = {w_clamp[NUM_W-1:1], 1'b0};
    assign w_cand  = r_lfsr[ADDR_W-1:0];
    assign w_busy  = (r_state == FILL) || (r_state == SHUFFLE) ||
                     (r_state == SWAP) || (r_state == EMIT);

    // Runs regardless of FSM state so the shuffle seed depends on when the player starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_n             <= '0;
            r_i             <= '0;
            r_j             <= '0;
            r_a             <= '0;
            compute_done    <= 1'b0;
            card_wr_en      <= 1'b0;
            card_wr_address <= '0;
            card_wr_color   <= '0;
            card_wr_state   <= 2'b00;
            for (int k = 0; k < SLOTS; k++) begin
                r_deck[k] <= '0;
            end
        end else begin
            card_wr_en <= 1'b0;
            if (w_busy && !start_game_en) begin
                r_state         <= IDLE;
                card_wr_address <= '0;
                card_wr_color   <= '0;
                card_wr_state   <= 2'b00;
            end else begin
                case (r_state)
                    IDLE: begin
                        compute_done    <= 1'b0;
                        card_wr_address <= '0;
                        card_wr_color   <= '0;
                        card_wr_state   <= 2'b00;
                        if (start_game_en) begin
                            r_n     <= w_n_req;
                            r_i     <= '0;
                            r_state <= FILL;
                        end
                    end
                    FILL: begin
                        r_deck[r_i] <= r_i[ADDR_W-1:1];
                        if (r_i == LAST) begin
                            if (r_n <= NUM_W'(2)) begin
                                r_a     <= '0;
                                r_state <= EMIT;
                            end else begin
                                r_i     <= ADDR_W'(r_n - NUM_W'(1));
                                r_state <= SHUFFLE;
                            end
                        end else begin
                            r_i <= r_i + ADDR_W'(1);
                        end
                    end
                    // Rejection sampling: a candidate above i is discarded and the next LFSR value tried.
                    SHUFFLE: begin
                        if (w_cand <= r_i) begin
                            r_j     <= w_cand;
                            r_state <= SWAP;
                        end
                    end
                    SWAP: begin
                        r_deck[r_i] <= r_deck[r_j];
                        r_deck[r_j] <= r_deck[r_i];
                        if (r_i == ADDR_W'(1)) begin
                            r_a     <= '0;
                            r_state <= EMIT;
                        end else begin
                            r_i     <= r_i - ADDR_W'(1);
                            r_state <= SHUFFLE;
                        end
                    end
                    EMIT: begin
                        card_wr_en      <= 1'b1;
                        card_wr_address <= r_a;
                        if (NUM_W'(r_a) < r_n) begin
                            card_wr_color <= COLOR_W'(PALETTE[r_deck[r_a]]);
                            card_wr_state <= 2'b01;
                        end else begin
                            card_wr_color <= '0;
                            card_wr_state <= 2'b00;
                        end
                        if (r_a == LAST) begin
                            r_state <= DONE;
                        end else begin
                            r_a <= r_a + ADDR_W'(1);
                        end
                    end
                    DONE: begin
                        card_wr_address <= '0;
                        card_wr_color   <= '0;
                        card_wr_state   <= 2'b00;
                        if (start_game_en) begin
                            compute_done <= 1'b1;
                        end else begin
                            compute_done <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
